pp_buffer_reader: RTL and testbench

//  Read-side sequencer for the ping-pong bit buffer. When the writer announces a full bank,
//  it issues read addresses 0..BLOCK_SIZE-1 and captures the 1-bit q after the buffer's
//  1-cycle read latency. It streams the bits downstream on a valid/ready handshake, then

---
 rtl/wimax_pkg.sv | 26 ++
 rtl/pp_addr_gen.sv | 42 ++++
 rtl/pp_buffer_reader.sv | 119 +++++++++++
 tb/tb_pp_buffer_reader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wimax_pkg.sv
// Shared constants, types and the 802.16 first-interleaver address map for the
// ping-pong buffer read path.
package wimax_pkg;

    localparam int unsigned BLOCK_SIZE = 192;
    localparam int unsigned ADDR_W     = 9;

    typedef enum logic {
        IDLE,
        RUN
    } rd_state_t;

    typedef struct packed {
        logic data;
        logic first;
        logic last;
    } skid_entry_t;

    // Depth-16 block interleaver: column-major read of a 16-row matrix.
    function automatic logic [ADDR_W-1:0] interleave_addr(input logic [ADDR_W-1:0] k);
        int unsigned kk;
        kk = 32'(k);
        return ADDR_W'((BLOCK_SIZE / 16) * (kk % 16) + kk / 16);
    endfunction

endpackage

// File: rtl/pp_addr_gen.sv
// Read index counter and index-to-address mapping. Defining PP_INTERLEAVE_EN
// selects the depth-16 interleaved read order; otherwise the read is linear.
module pp_addr_gen
    import wimax_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              first_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] KLast = ADDR_W'(BLOCK_SIZE - 1);

    logic [ADDR_W-1:0] k_q, k_d;

    assign first_o = (k_q == '0);
    assign last_o  = (k_q == KLast);

    always_comb begin
        k_d = k_q;
        if (adv_i) begin
            k_d = last_o ? '0 : k_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

`ifdef PP_INTERLEAVE_EN
    assign addr_o = interleave_addr(k_q);
`else
    assign addr_o = k_q;
`endif

endmodule

// File: rtl/pp_buffer_reader.sv
// Read-side sequencer of the ping-pong bit buffer: issues bank reads, absorbs the
// 1-cycle RAM latency in a 2-entry skid and streams bits on valid/ready.
module pp_buffer_reader
    import wimax_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              bank_ready_i,
    input  logic              q_i,
    output logic [ADDR_W-1:0] rdaddress_o,
    output logic              rd_en_o,
    output logic              rd_bank_o,
    output logic              data_out_o,
    output logic              valid_out_o,
    input  logic              ready_in_i,
    output logic              first_out_o,
    output logic              last_out_o,
    output logic              busy_o,
    output logic              overflow_o
);

    rd_state_t        state_q, state_d;
    logic [1:0]       pending_q, pending_d;
    logic             rd_bank_q, rd_bank_d;
    logic             overflow_q, overflow_d;
    logic             inflight_q, infl_first_q, infl_last_q;
    skid_entry_t [1:0] skid_q, skid_d;
    logic [1:0]       skid_cnt_q, skid_cnt_d;

    logic             rd_en, addr_first, addr_last, pop, inc, dec;
    logic [2:0]       occ;

    pp_addr_gen u_addr_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .adv_i   (rd_en),
        .addr_o  (rdaddress_o),
        .first_o (addr_first),
        .last_o  (addr_last)
    );

    assign valid_out_o = (skid_cnt_q != 2'd0);
    assign pop         = valid_out_o && ready_in_i;
    // Skid occupancy after this edge; counting the pop keeps 1 bit/cycle sustained.
    assign occ         = 3'(skid_cnt_q) + 3'(inflight_q) - 3'(pop);

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        rd_bank_d  = rd_bank_q;
        overflow_d = overflow_q;
        rd_en      = 1'b0;
        unique case (state_q)
            IDLE: rd_en = 1'b0;
            RUN:  rd_en = (occ < 3'd2);
            default: rd_en = 1'b0;
        endcase
        inc = bank_ready_i && (pending_q != 2'd2);
        dec = rd_en && addr_last;
        if (bank_ready_i && (pending_q == 2'd2)) begin
            overflow_d = 1'b1;
        end
        if (dec) begin
            rd_bank_d = ~rd_bank_q;
        end
        if (inc && !dec) begin
            pending_d = pending_q + 2'd1;
        end else if (dec && !inc) begin
            pending_d = pending_q - 2'd1;
        end
        state_d = (pending_d != 2'd0) ? RUN : IDLE;
    end

    always_comb begin
        skid_d     = skid_q;
        skid_cnt_d = skid_cnt_q;
        if (pop) begin
            skid_d[0]  = skid_q[1];
            skid_cnt_d = skid_cnt_q - 2'd1;
        end
        if (inflight_q) begin
            skid_d[skid_cnt_d[0]] = '{data: q_i, first: infl_first_q, last: infl_last_q};
            skid_cnt_d            = skid_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            pending_q    <= 2'd0;
            rd_bank_q    <= 1'b0;
            overflow_q   <= 1'b0;
            inflight_q   <= 1'b0;
            infl_first_q <= 1'b0;
            infl_last_q  <= 1'b0;
            skid_q       <= '0;
            skid_cnt_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            rd_bank_q    <= rd_bank_d;
            overflow_q   <= overflow_d;
            inflight_q   <= rd_en;
            infl_first_q <= addr_first;
            infl_last_q  <= addr_last;
            skid_q       <= skid_d;
            skid_cnt_q   <= skid_cnt_d;
        end
    end

    assign rd_en_o     = rd_en;
    assign rd_bank_o   = rd_bank_q;
    assign overflow_o  = overflow_q;
    assign data_out_o  = valid_out_o && skid_q[0].data;
    assign first_out_o = valid_out_o && skid_q[0].first;
    assign last_out_o  = valid_out_o && skid_q[0].last;
    assign busy_o      = (pending_q != 2'd0) || inflight_q || valid_out_o;

endmodule

// File: tb/tb_pp_buffer_reader.sv
// Directed bench for pp_buffer_reader with a 2-bank, 1-cycle-latency buffer model.
// Expected read order follows PP_INTERLEAVE_EN when it is defined.
module tb_pp_buffer_reader;

    localparam logic [191:0] PAT0 = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bank_ready = 1'b0;
    logic       q = 1'b0;
    logic [8:0] rdaddress;
    logic       rd_en, rd_bank, data_out, valid_out, first_out, last_out, busy, overflow;
    logic       ready_in = 1'b1;

    logic [191:0] mem [2];

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    int stall_err = 0;

    logic out_bits[$];
    logic out_first[$];
    logic out_last[$];
    int   out_cyc[$];
    logic [8:0] addr_log[$];
    logic bank_log[$];

    logic hold_v = 1'b0;
    logic hold_d, hold_f, hold_l;

    pp_buffer_reader dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .bank_ready_i (bank_ready),
        .q_i          (q),
        .rdaddress_o  (rdaddress),
        .rd_en_o      (rd_en),
        .rd_bank_o    (rd_bank),
        .data_out_o   (data_out),
        .valid_out_o  (valid_out),
        .ready_in_i   (ready_in),
        .first_out_o  (first_out),
        .last_out_o   (last_out),
        .busy_o       (busy),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) q <= mem[rd_bank][rdaddress];
    end

    always @(negedge clk) begin
        if (!reset) begin
            cyc++;
            if (rd_en) begin
                addr_log.push_back(rdaddress);
                bank_log.push_back(rd_bank);
            end
            if (hold_v && (!valid_out || data_out !== hold_d || first_out !== hold_f ||
                           last_out !== hold_l)) stall_err++;
            if (valid_out && ready_in) begin
                out_bits.push_back(data_out);
                out_first.push_back(first_out);
                out_last.push_back(last_out);
                out_cyc.push_back(cyc);
            end
            hold_v = valid_out && !ready_in;
            hold_d = data_out;
            hold_f = first_out;
            hold_l = last_out;
        end else begin
            hold_v = 1'b0;
        end
    end

    function automatic int perm(input int k);
`ifdef PP_INTERLEAVE_EN
        return 12 * (k % 16) + k / 16;
`else
        return k;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        bank_ready = 1'b1;
        tick();
        bank_ready = 1'b0;
    endtask

    task automatic clear_logs();
        out_bits.delete();
        out_first.delete();
        out_last.delete();
        out_cyc.delete();
        addr_log.delete();
        bank_log.delete();
        stall_err = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_bits(input string tag, input int n, input int budget);
        int c = 0;
        while (out_bits.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk(tag, 32'(out_bits.size() >= n), 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        while (busy && c < budget) begin
            tick();
            c++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    task automatic cmp_block(input string tag, input int base, input int bank);
        int errs = 0;
        for (int k = 0; k < 192; k++) begin
            if (base + k >= out_bits.size()) begin
                errs++;
            end else begin
                if (out_bits[base+k] !== mem[bank][perm(k)]) errs++;
                if (out_first[base+k] !== (k == 0)) errs++;
                if (out_last[base+k] !== (k == 191)) errs++;
            end
        end
        chk(tag, 32'(errs), 0);
    endtask

    initial begin
        logic sent;
        int   c;
        mem[0] = PAT0;
        mem[1] = PAT0 ^ {6{32'hDEADBEEF}};

        // Reset state
        tick();
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_rd_bank", 32'(rd_bank), 0);
        do_reset();

        // 1: single bank, ready held high, latency and framing
        ready_in = 1'b1;
        pulse();
        chk("t1_rd_en_after_e0", 32'(rd_en), 1);
        chk("t1_addr0", 32'(rdaddress), 0);
        chk("t1_busy", 32'(busy), 1);
        tick();
        chk("t1_valid_e1", 32'(valid_out), 0);
        tick();
        chk("t1_valid_e2", 32'(valid_out), 1);
        chk("t1_first_e2", 32'(first_out), 1);
        chk("t1_bit0", 32'(data_out), 32'(mem[0][perm(0)]));
        wait_bits("t1_timeout", 192, 400);
        cmp_block("t1_block", 0, 0);
        chk("t1_contig", 32'(out_cyc[191] - out_cyc[0]), 191);
        wait_idle("t1_idle", 20);
        chk("t1_count", 32'(out_bits.size()), 192);

        // 6: read address order (k=1, k=16, k=191)
        chk("t6_nreads", 32'(addr_log.size()), 192);
`ifdef PP_INTERLEAVE_EN
        chk("t6_addr_k1", 32'(addr_log[1]), 12);
        chk("t6_addr_k16", 32'(addr_log[16]), 1);
`else
        chk("t6_addr_k1", 32'(addr_log[1]), 1);
        chk("t6_addr_k16", 32'(addr_log[16]), 16);
`endif
        chk("t6_addr_k191", 32'(addr_log[191]), 191);

        // 2: back-to-back banks, no bubble
        do_reset();
        pulse();
        repeat (191) tick();
        pulse();
        wait_bits("t2_timeout", 384, 800);
        cmp_block("t2_block0", 0, 0);
        cmp_block("t2_block1", 192, 1);
        chk("t2_contig", 32'(out_cyc[383] - out_cyc[0]), 383);
        chk("t2_bank_first", 32'(bank_log[0]), 0);
        chk("t2_bank_191", 32'(bank_log[191]), 0);
        chk("t2_bank_192", 32'(bank_log[192]), 1);
        chk("t2_bank_383", 32'(bank_log[383]), 1);
        wait_idle("t2_idle", 20);
        chk("t2_rd_bank_end", 32'(rd_bank), 0);

        // 3: random backpressure over three blocks
        do_reset();
        pulse();
        pulse();
        sent = 1'b0;
        c = 0;
        while (out_bits.size() < 576 && c < 5000) begin
            ready_in   = 1'($urandom_range(0, 1));
            bank_ready = !sent && (bank_log.size() >= 192);
            if (bank_ready) sent = 1'b1;
            tick();
            c++;
        end
        bank_ready = 1'b0;
        ready_in   = 1'b1;
        wait_idle("t3_idle", 50);
        chk("t3_count", 32'(out_bits.size()), 576);
        cmp_block("t3_block0", 0, 0);
        cmp_block("t3_block1", 192, 1);
        cmp_block("t3_block2", 384, 0);
        chk("t3_stall_stable", 32'(stall_err), 0);
        chk("t3_no_overflow", 32'(overflow), 0);

        // 4: overflow with downstream blocked
        do_reset();
        ready_in = 1'b0;
        pulse();
        pulse();
        pulse();
        repeat (10) tick();
        chk("t4_overflow", 32'(overflow), 1);
        chk("t4_busy", 32'(busy), 1);
        chk("t4_valid_held", 32'(valid_out), 1);
        chk("t4_no_output", 32'(out_bits.size()), 0);
        ready_in = 1'b1;
        wait_idle("t4_idle", 1000);
        chk("t4_count", 32'(out_bits.size()), 384);
        cmp_block("t4_block0", 0, 0);
        cmp_block("t4_block1", 192, 1);
        chk("t4_overflow_sticky", 32'(overflow), 1);

        // 5: reset at output bit 100
        do_reset();
        pulse();
        c = 0;
        while (out_bits.size() < 100 && c < 300) begin
            tick();
            c++;
        end
        chk("t5_at_bit100", 32'(out_bits.size()), 100);
        chk("t5_valid_before", 32'(valid_out), 1);
        reset = 1'b1;
        #1;
        chk("t5_valid_dropped", 32'(valid_out), 0);
        chk("t5_busy_dropped", 32'(busy), 0);
        chk("t5_rd_en_dropped", 32'(rd_en), 0);
        tick();
        reset = 1'b0;
        clear_logs();
        chk("t5_rd_bank", 32'(rd_bank), 0);
        pulse();
        wait_bits("t5_timeout", 192, 400);
        cmp_block("t5_block", 0, 0);
        chk("t5_restart_addr", 32'(addr_log[0]), 0);
        chk("t5_restart_bank", 32'(bank_log[0]), 0);
        wait_idle("t5_idle", 20);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1);
    end

endmodule
